// File: rtl/spi_mailbox_pkg.sv
// Shared constants, FSM state type and index helpers for the SPI mailbox slave.
// Optional feature macro: SPI_STATUS_IRQ_EN (adds the registered cpu_irq output).
`timescale 1ns/1ps
package spi_mailbox_pkg;

    localparam int unsigned CMD_W       = 8;
    localparam int unsigned FRAME_BITS  = 24;
    localparam int unsigned NREGS       = 8;
    localparam logic [3:0]  STATUS_IDX  = 4'd8;
    localparam int unsigned PI2CPU_LAST = 3;

    // Wide enough to count a full frame.
    localparam int unsigned CNT_W = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } state_t;

    // Registers 0..3 carry Pi->CPU traffic.
    function automatic logic is_pi2cpu(input logic [3:0] idx);
        return idx <= 4'(PI2CPU_LAST);
    endfunction

    // Registers 4..7 carry CPU->Pi traffic.
    function automatic logic is_cpu2pi(input logic [3:0] idx);
        return (idx > 4'(PI2CPU_LAST)) && (idx < 4'(NREGS));
    endfunction

endpackage

// File: rtl/spi_mailbox_slave_if.sv
// SPI pins plus CPU data-bus signals of the mailbox slave.
// Optional feature macro: SPI_STATUS_IRQ_EN (adds cpu_irq).
`timescale 1ns/1ps
interface spi_mailbox_slave_if #(
    parameter int unsigned DATA_W = 16
);

    logic              spi_sclk;
    logic              spi_cs_n;
    logic              spi_mosi;
    logic              spi_miso;
    logic              cpu_sel;
    logic              cpu_we;
    logic [3:0]        cpu_reg;
    logic [DATA_W-1:0] cpu_wdata;
    logic [DATA_W-1:0] cpu_rdata;
    logic [3:0]        pi_flags;
`ifdef SPI_STATUS_IRQ_EN
    logic              cpu_irq;

    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, cpu_sel, cpu_we, cpu_reg, cpu_wdata,
        input  spi_miso, cpu_rdata, pi_flags, cpu_irq
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, cpu_sel, cpu_we, cpu_reg, cpu_wdata,
        output spi_miso, cpu_rdata, pi_flags, cpu_irq
    );
`else
    modport master (
        output spi_sclk, spi_cs_n, spi_mosi, cpu_sel, cpu_we, cpu_reg, cpu_wdata,
        input  spi_miso, cpu_rdata, pi_flags
    );

    modport slave (
        input  spi_sclk, spi_cs_n, spi_mosi, cpu_sel, cpu_we, cpu_reg, cpu_wdata,
        output spi_miso, cpu_rdata, pi_flags
    );
`endif

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input, with 1-cycle rise/fall pulses.
`timescale 1ns/1ps
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Synchronizer chain plus a delayed copy of its output for edge detection.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/spi_mailbox_slave.sv
// SPI mode-0 slave exposing eight 16-bit mailbox registers to the CPU data bus.
// Frame: 8-bit command (bit 7 = write, bits 2:0 = index) then 16 data bits, MSB first.
// Optional feature macro: SPI_STATUS_IRQ_EN (registered cpu_irq = |pi_flags).
`timescale 1ns/1ps
module spi_mailbox_slave
    import spi_mailbox_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    spi_mailbox_slave_if.slave bus
);

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_W - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_n_level, cs_n_rise, cs_n_fall;
    logic mosi_level, mosi_rise, mosi_fall;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] tx_q, tx_d;
    logic              miso_q, miso_d;
    logic              cmd_we_q, cmd_we_d;
    logic [2:0]        cmd_idx_q, cmd_idx_d;
    logic              commit;
    logic [DATA_W-1:0] commit_data;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [3:0]        flags_q, flags_d;
    logic [DATA_W-1:0] rdata;
    logic              cpu_wr, cpu_rd;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .reset (reset),
        .din   (bus.spi_sclk),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    // cs_n idles high, so reset it high to avoid a false select on reset release.
    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b1)
    ) u_sync_cs_n (
        .clk   (clk),
        .reset (reset),
        .din   (bus.spi_cs_n),
        .level (cs_n_level),
        .rise  (cs_n_rise),
        .fall  (cs_n_fall)
    );

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES),
        .RESET_VAL   (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .reset (reset),
        .din   (bus.spi_mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    // Only edges of sclk/cs_n and the level of mosi are needed.
    logic unused_sync;
    assign unused_sync = ^{sclk_level, cs_n_level, mosi_rise, mosi_fall};

    assign cpu_wr      = bus.cpu_sel & bus.cpu_we;
    assign cpu_rd      = bus.cpu_sel & ~bus.cpu_we;
    assign commit_data = {rx_q[DATA_W-2:0], mosi_level};

    // Frame FSM state and shifter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            miso_q    <= 1'b0;
            cmd_we_q  <= 1'b0;
            cmd_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            miso_q    <= miso_d;
            cmd_we_q  <= cmd_we_d;
            cmd_idx_q <= cmd_idx_d;
        end
    end

    // Frame FSM next-state: shift on sclk rise, drive miso on sclk fall.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        miso_d    = miso_q;
        cmd_we_d  = cmd_we_q;
        cmd_idx_d = cmd_idx_q;
        commit    = 1'b0;
        unique case (state_q)
            IDLE: begin
                miso_d = 1'b0;
                if (cs_n_fall) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                miso_d = 1'b0;
                if (cs_n_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d      = commit_data;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CMD_LAST) begin
                        // cmd[7] has been shifted up to rx_q[6] by now.
                        cmd_we_d  = rx_q[CMD_W-2];
                        cmd_idx_d = {rx_q[1:0], mosi_level};
                        // Pre-write value: a same-cycle CPU write lands after this read.
                        tx_d      = regs_q[cmd_idx_d];
                        state_d   = DATA;
                    end
                end
            end
            DATA: begin
                if (cs_n_rise) begin
                    state_d = IDLE;
                    miso_d  = 1'b0;
                end else begin
                    if (sclk_fall) begin
                        miso_d = tx_q[DATA_W-1];
                        tx_d   = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        rx_d      = commit_data;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == FRAME_LAST) begin
                            state_d = DONE;
                            miso_d  = 1'b0;
                            commit  = cmd_we_q & is_pi2cpu({1'b0, cmd_idx_q});
                        end
                    end
                end
            end
            DONE: begin
                miso_d = 1'b0;
                if (cs_n_rise) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                miso_d  = 1'b0;
            end
        endcase
    end

    // Flag update: CPU read clears, SPI commit sets; set is applied last so it wins.
    always_comb begin
        flags_d = flags_q;
        if (cpu_rd && is_pi2cpu(bus.cpu_reg)) begin
            flags_d[bus.cpu_reg[1:0]] = 1'b0;
        end
        if (commit) begin
            flags_d[cmd_idx_q[1:0]] = 1'b1;
        end
    end

    // Mailbox storage: Pi commits to 0..3, CPU writes to 4..7, so they never collide.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            if (commit) begin
                regs_q[cmd_idx_q] <= commit_data;
            end
            if (cpu_wr && is_cpu2pi(bus.cpu_reg)) begin
                regs_q[bus.cpu_reg[2:0]] <= bus.cpu_wdata;
            end
            flags_q <= flags_d;
        end
    end

    // Combinational CPU read mux: mailbox, status word, or zero.
    always_comb begin
        rdata = '0;
        if (!bus.cpu_reg[3]) begin
            rdata = regs_q[bus.cpu_reg[2:0]];
        end else if (bus.cpu_reg == STATUS_IDX) begin
            rdata = {{(DATA_W-4){1'b0}}, flags_q};
        end
    end

    assign bus.spi_miso  = miso_q;
    assign bus.cpu_rdata = rdata;
    assign bus.pi_flags  = flags_q;

`ifdef SPI_STATUS_IRQ_EN
    logic irq_q;

    // Interrupt follows any pending Pi->CPU flag, one cycle later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |flags_q;
        end
    end

    assign bus.cpu_irq = irq_q;
`endif

endmodule

// File: tb/tb_spi_mailbox_slave.sv
// Directed bench for spi_mailbox_slave: table-driven CPU and SPI frame vectors plus
// hand-written abort, set-wins, mid-frame reset and over-long frame sequences.
`timescale 1ns/1ps
module tb_spi_mailbox_slave;

    localparam int HALF = 5;  // sclk half period in clk cycles (sclk = clk/10)

    typedef struct {
        logic        we;
        logic [3:0]  idx;
        logic [15:0] data;  // write data, or expected read data
    } cpu_vec_t;

    typedef struct {
        logic [7:0]  cmd;
        logic [15:0] data;
        logic [3:0]  flags;
        logic [15:0] miso;
        logic [3:0]  chk_idx;
        logic [15:0] chk_val;
        logic [3:0]  flags_after;
    } frame_vec_t;

    logic clk;
    logic reset;

    spi_mailbox_slave_if #(.DATA_W(16)) bus ();

    spi_mailbox_slave #(
        .SYNC_STAGES (2),
        .DATA_W      (16)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    cpu_vec_t   cvec [17];
    frame_vec_t fvec [7];
    logic [15:0] rd;
    logic [31:0] rxw;
    logic        seen;

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cpu_write(input logic [3:0] idx, input logic [15:0] data);
        @(negedge clk);
        bus.cpu_sel   = 1'b1;
        bus.cpu_we    = 1'b1;
        bus.cpu_reg   = idx;
        bus.cpu_wdata = data;
        @(negedge clk);
        bus.cpu_sel   = 1'b0;
        bus.cpu_we    = 1'b0;
    endtask

    task automatic cpu_read(input logic [3:0] idx, output logic [15:0] data);
        @(negedge clk);
        bus.cpu_sel = 1'b1;
        bus.cpu_we  = 1'b0;
        bus.cpu_reg = idx;
        #1;
        data = bus.cpu_rdata;
        @(negedge clk);
        bus.cpu_sel = 1'b0;
    endtask

    // Mode-0 master: mosi changes with sclk low, miso sampled on each rise.
    task automatic spi_frame(input int nbits, input logic [31:0] word, output logic [31:0] rx);
        rx = '0;
        @(negedge clk);
        bus.spi_cs_n = 1'b0;
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.spi_mosi = word[i];
            repeat (HALF) @(negedge clk);
            bus.spi_sclk = 1'b1;
            rx = {rx[30:0], bus.spi_miso};
            repeat (HALF) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
        repeat (HALF) @(negedge clk);
        bus.spi_cs_n = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        // CPU-side vectors: reads before writes see reset zeros, illegal writes ignored.
        cvec[0]  = '{1'b0, 4'd0,  16'h0000};
        cvec[1]  = '{1'b0, 4'd4,  16'h0000};
        cvec[2]  = '{1'b0, 4'd7,  16'h0000};
        cvec[3]  = '{1'b0, 4'd8,  16'h0000};
        cvec[4]  = '{1'b0, 4'd9,  16'h0000};
        cvec[5]  = '{1'b1, 4'd5,  16'h1234};
        cvec[6]  = '{1'b1, 4'd6,  16'h5555};
        cvec[7]  = '{1'b1, 4'd0,  16'hAAAA};
        cvec[8]  = '{1'b1, 4'd8,  16'hFFFF};
        cvec[9]  = '{1'b1, 4'd15, 16'hFFFF};
        cvec[10] = '{1'b1, 4'd4,  16'hA5A5};
        cvec[11] = '{1'b0, 4'd5,  16'h1234};
        cvec[12] = '{1'b0, 4'd6,  16'h5555};
        cvec[13] = '{1'b0, 4'd0,  16'h0000};
        cvec[14] = '{1'b0, 4'd8,  16'h0000};
        cvec[15] = '{1'b0, 4'd4,  16'hA5A5};
        cvec[16] = '{1'b0, 4'd15, 16'h0000};

        // SPI frames: cmd, data, flags after frame, miso word, CPU read idx/value, flags after.
        fvec[0] = '{8'h81, 16'hBEEF, 4'b0010, 16'h0000, 4'd1, 16'hBEEF, 4'b0000};
        fvec[1] = '{8'h05, 16'h0000, 4'b0000, 16'h1234, 4'd5, 16'h1234, 4'b0000};
        fvec[2] = '{8'h86, 16'hFFFF, 4'b0000, 16'h5555, 4'd6, 16'h5555, 4'b0000};
        fvec[3] = '{8'h01, 16'h0000, 4'b0000, 16'hBEEF, 4'd1, 16'hBEEF, 4'b0000};
        fvec[4] = '{8'hF8, 16'h0F0F, 4'b0001, 16'h0000, 4'd8, 16'h0001, 4'b0001};
        fvec[5] = '{8'h83, 16'hC3A5, 4'b1001, 16'h0000, 4'd0, 16'h0F0F, 4'b1000};
        fvec[6] = '{8'h03, 16'h0000, 4'b1000, 16'hC3A5, 4'd3, 16'hC3A5, 4'b0000};

        reset         = 1'b0;
        bus.spi_sclk  = 1'b0;
        bus.spi_cs_n  = 1'b1;
        bus.spi_mosi  = 1'b0;
        bus.cpu_sel   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_reg   = 4'd0;
        bus.cpu_wdata = 16'h0000;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        check("reset_miso", 32'(bus.spi_miso), 32'd0);
        check("reset_flags", 32'(bus.pi_flags), 32'd0);
`ifdef SPI_STATUS_IRQ_EN
        check("reset_irq", 32'(bus.cpu_irq), 32'd0);
`endif

        for (int i = 0; i < 17; i++) begin
            if (cvec[i].we) begin
                cpu_write(cvec[i].idx, cvec[i].data);
            end else begin
                cpu_read(cvec[i].idx, rd);
                check($sformatf("cpu_vec%0d_rd%0d", i, cvec[i].idx), 32'(rd),
                      32'(cvec[i].data));
            end
        end

        for (int i = 0; i < 7; i++) begin
            spi_frame(24, {8'h00, fvec[i].cmd, fvec[i].data}, rxw);
            check($sformatf("frame%0d_flags", i), 32'(bus.pi_flags), 32'(fvec[i].flags));
            check($sformatf("frame%0d_miso", i), rxw, {16'h0000, fvec[i].miso});
            cpu_read(4'd8, rd);
            check($sformatf("frame%0d_status", i), 32'(rd), 32'(fvec[i].flags));
            cpu_read(fvec[i].chk_idx, rd);
            check($sformatf("frame%0d_rd%0d", i, fvec[i].chk_idx), 32'(rd),
                  32'(fvec[i].chk_val));
            @(negedge clk);
            check($sformatf("frame%0d_flags_after", i), 32'(bus.pi_flags),
                  32'(fvec[i].flags_after));
        end

        // Abort after 15 bits of a write to reg2, then a full frame must still work.
        spi_frame(15, 32'({8'h82, 16'hFFFF} >> 9), rxw);
        check("abort_flags", 32'(bus.pi_flags), 32'd0);
        cpu_read(4'd2, rd);
        check("abort_reg2", 32'(rd), 32'd0);
        spi_frame(24, {8'h00, 8'h82, 16'h7E81}, rxw);
        check("post_abort_flags", 32'(bus.pi_flags), 32'h4);
        cpu_read(4'd2, rd);
        check("post_abort_reg2", 32'(rd), 32'h7E81);
        @(negedge clk);
        check("post_abort_clear", 32'(bus.pi_flags), 32'd0);

        // Hold a CPU read of reg3 across the commit; release it the cycle the flag shows.
        @(negedge clk);
        bus.cpu_sel = 1'b1;
        bus.cpu_we  = 1'b0;
        bus.cpu_reg = 4'd3;
        seen        = 1'b0;
        fork
            spi_frame(24, {8'h00, 8'h83, 16'h6006}, rxw);
            begin
                for (int n = 0; n < 2000 && !seen; n++) begin
                    @(negedge clk);
                    if (bus.pi_flags[3]) begin
                        seen        = 1'b1;
                        bus.cpu_sel = 1'b0;
                    end
                end
                bus.cpu_sel = 1'b0;
            end
        join
        check("setwins_seen", 32'(seen), 32'd1);
        check("setwins_flags", 32'(bus.pi_flags), 32'h8);
`ifdef SPI_STATUS_IRQ_EN
        check("setwins_irq", 32'(bus.cpu_irq), 32'd1);
`endif

        // Reset in the middle of the data phase of a read-back of reg0 (0x0F0F).
        fork
            spi_frame(24, {8'h00, 8'h80, 16'hFFFF}, rxw);
            begin
                repeat (150) @(negedge clk);
                check("pre_reset_miso", 32'(bus.spi_miso), 32'd1);
                reset = 1'b0;
                #1;
                check("midreset_miso", 32'(bus.spi_miso), 32'd0);
                check("midreset_flags", 32'(bus.pi_flags), 32'd0);
                bus.cpu_reg = 4'd5;
                #1;
                check("midreset_reg5", 32'(bus.cpu_rdata), 32'd0);
                bus.cpu_reg = 4'd3;
                #1;
                check("midreset_reg3", 32'(bus.cpu_rdata), 32'd0);
            end
        join
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        cpu_read(4'd0, rd);
        check("postreset_reg0", 32'(rd), 32'd0);
        check("postreset_flags", 32'(bus.pi_flags), 32'd0);

        // 32-bit frames: first 24 bits honoured, trailing byte ignored and miso held low.
        spi_frame(32, {8'h82, 16'h1357, 8'hFF}, rxw);
        check("long_write_flags", 32'(bus.pi_flags), 32'h4);
        check("long_write_miso", rxw, 32'd0);
        spi_frame(32, {8'h02, 16'h0000, 8'hFF}, rxw);
        check("long_read_miso", rxw, {8'h00, 16'h1357, 8'h00});
        cpu_read(4'd2, rd);
        check("long_reg2", 32'(rd), 32'h1357);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
